// File: rtl/fmul_36bit_arbiter_if.sv
// Client-side and multiplier-side signal bundle for fmul_36bit_arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (requesters plus the shared multiplier).
interface fmul_36bit_arbiter_if #(
  parameter int P_N = 4
);
  // Requester issue side
  logic [P_N-1:0]    iREQ_REQ;
  logic [P_N-1:0]    oREQ_BUSY;
  logic [P_N*36-1:0] iREQ_A;
  logic [P_N*36-1:0] iREQ_B;
  // Requester result side
  logic [P_N-1:0]    oRES_VALID;
  logic [P_N-1:0]    iRES_BUSY;
  logic [35:0]       oRES_DATA;
  // Multiplier input side
  logic              oMUL_REQ;
  logic              iMUL_BUSY;
  logic [35:0]       oMUL_A;
  logic [35:0]       oMUL_B;
  // Multiplier output side
  logic              iMUL_VALID;
  logic              oMUL_BUSY;
  logic [35:0]       iMUL_DATA;
  // Status
  logic              oERR_ORPHAN;

  modport slave (
    input  iREQ_REQ, iREQ_A, iREQ_B, iRES_BUSY, iMUL_BUSY, iMUL_VALID, iMUL_DATA,
    output oREQ_BUSY, oRES_VALID, oRES_DATA, oMUL_REQ, oMUL_A, oMUL_B, oMUL_BUSY,
           oERR_ORPHAN
  );

  modport master (
    output iREQ_REQ, iREQ_A, iREQ_B, iRES_BUSY, iMUL_BUSY, iMUL_VALID, iMUL_DATA,
    input  oREQ_BUSY, oRES_VALID, oRES_DATA, oMUL_REQ, oMUL_A, oMUL_B, oMUL_BUSY,
           oERR_ORPHAN
  );
endinterface

// File: rtl/fmul_36bit_arbiter.sv
// Round-robin sharing of one fmul_36bit among P_N requesters. A tag FIFO
// remembers which requester issued each in-flight op so every result is
// steered back to its issuer in issue order.
//
// Handshake semantics (every channel): a word moves on a clock edge where the
// sender's REQ/VALID is 1 and the receiver's BUSY is 0. While BUSY is 1 the
// sender holds REQ/VALID and data stable.
module fmul_36bit_arbiter #(
  parameter int P_N         = 4,
  parameter int P_TAG_DEPTH = 8
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  fmul_36bit_arbiter_if.slave bus
);

  localparam int TW = (P_N > 1) ? $clog2(P_N) : 1;
  localparam int AW = $clog2(P_TAG_DEPTH);
  localparam int CW = AW + 1;

  logic [TW-1:0] rrPtr;
  logic [TW-1:0] grantIdx;
  logic [TW:0]   rrSum;
  logic          grantFound;
  logic [35:0]   selA;
  logic [35:0]   selB;

  logic          mulReq;
  logic [35:0]   mulA;
  logic [35:0]   mulB;
  logic          errOrphan;

  logic [TW-1:0] tagMem [P_TAG_DEPTH];
  logic [AW-1:0] tagWr;
  logic [AW-1:0] tagRd;
  logic [CW-1:0] tagCount;
  logic [TW-1:0] headTag;

  logic          rstActive;
  logic          tagEmpty;
  logic          tagFull;
  logic          accept;
  logic          resValid;
  logic          pop;
  logic [P_N-1:0] reqBusyVec;
  logic [P_N-1:0] resValidVec;

  // Either reset form blanks the handshake outputs while it is active.
  assign rstActive = !inRESET || iRESET_SYNC;
  assign tagEmpty  = (tagCount == '0);
  assign tagFull   = (tagCount == CW'(P_TAG_DEPTH));
  assign headTag   = tagMem[tagRd];

  // First requesting port at or above rrPtr, wrapping past P_N-1.
  always_comb begin
    grantIdx   = rrPtr;
    grantFound = 1'b0;
    rrSum      = '0;
    for (int k = 0; k < P_N; k++) begin
      rrSum = {1'b0, rrPtr} + (TW+1)'(k);
      if (rrSum >= (TW+1)'(P_N)) rrSum = rrSum - (TW+1)'(P_N);
      if (!grantFound && bus.iREQ_REQ[rrSum[TW-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = rrSum[TW-1:0];
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int n = 0; n < P_N; n++) begin
      if (grantIdx == TW'(n)) begin
        selA = bus.iREQ_A[36*n +: 36];
        selB = bus.iREQ_B[36*n +: 36];
      end
    end
  end

  // The staging register can take a new op when it is empty or draining.
  assign accept = !rstActive && (!mulReq || !bus.iMUL_BUSY) && !tagFull && grantFound;

  assign resValid = bus.iMUL_VALID && !tagEmpty && !rstActive;
  assign pop      = resValid && !bus.iRES_BUSY[headTag];

  // Per-requester stall and result-valid vectors.
  always_comb begin
    reqBusyVec  = '1;
    resValidVec = '0;
    if (accept)   reqBusyVec[grantIdx]  = 1'b0;
    if (resValid) resValidVec[headTag]  = 1'b1;
  end

  // Staging register toward the multiplier and the round-robin pointer.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mulReq <= 1'b0;
      mulA   <= '0;
      mulB   <= '0;
      rrPtr  <= '0;
    end else if (iRESET_SYNC) begin
      mulReq <= 1'b0;
      mulA   <= '0;
      mulB   <= '0;
      rrPtr  <= '0;
    end else if (accept) begin
      mulReq <= 1'b1;
      mulA   <= selA;
      mulB   <= selB;
      rrPtr  <= (grantIdx == TW'(P_N-1)) ? '0 : grantIdx + TW'(1);
    end else if (!bus.iMUL_BUSY) begin
      mulReq <= 1'b0;
    end
  end

  // Tag storage; entries are only meaningful between push and pop.
  always_ff @(posedge iCLOCK) begin
    if (accept) tagMem[tagWr] <= grantIdx;
  end

  // Tag FIFO pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      tagWr    <= '0;
      tagRd    <= '0;
      tagCount <= '0;
    end else if (iRESET_SYNC) begin
      tagWr    <= '0;
      tagRd    <= '0;
      tagCount <= '0;
    end else begin
      if (accept) tagWr <= tagWr + 1'b1;
      if (pop)    tagRd <= tagRd + 1'b1;
      case ({accept, pop})
        2'b10:   tagCount <= tagCount + 1'b1;
        2'b01:   tagCount <= tagCount - 1'b1;
        default: tagCount <= tagCount;
      endcase
    end
  end

  // Sticky flag for a multiplier result that no outstanding tag can claim.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      errOrphan <= 1'b0;
    end else if (iRESET_SYNC) begin
      errOrphan <= 1'b0;
    end else if (bus.iMUL_VALID && tagEmpty) begin
      errOrphan <= 1'b1;
    end
  end

  assign bus.oREQ_BUSY   = reqBusyVec;
  assign bus.oRES_VALID  = resValidVec;
  assign bus.oRES_DATA   = bus.iMUL_DATA;
  assign bus.oMUL_REQ    = mulReq;
  assign bus.oMUL_A      = mulA;
  assign bus.oMUL_B      = mulB;
  // An orphan result sees no stall, so the multiplier drops it.
  assign bus.oMUL_BUSY   = !tagEmpty && bus.iRES_BUSY[headTag];
  assign bus.oERR_ORPHAN = errOrphan;

endmodule

// File: tb/tb_fmul_36bit_arbiter.sv
// Directed bench for fmul_36bit_arbiter with a queue-based multiplier model
// (3-cycle latency, output stall honoured, input busy when 8 ops held).
module tb_fmul_36bit_arbiter;

  localparam int P_N = 4;
  localparam int P_TAG_DEPTH = 8;
  localparam logic [35:0] ONE = 36'h3ff000000;

  // Clock / reset
  logic iCLOCK = 1'b0;
  logic inRESET;
  logic iRESET_SYNC;
  always #5 iCLOCK = ~iCLOCK;

  fmul_36bit_arbiter_if #(.P_N(P_N)) bus();

  fmul_36bit_arbiter #(.P_N(P_N), .P_TAG_DEPTH(P_TAG_DEPTH)) dut (
    .iCLOCK(iCLOCK),
    .inRESET(inRESET),
    .iRESET_SYNC(iRESET_SYNC),
    .bus(bus)
  );

  // Multiplier model
  logic [35:0] mQueue[$];
  int          mRdy[$];
  int          mCyc = 0;
  logic        mValid = 1'b0;
  logic        mFull = 1'b0;
  logic [35:0] mData = '0;
  logic        forceBusy;
  logic        injValid;
  logic [35:0] injData;

  function automatic logic [35:0] mulModel(input logic [35:0] a, input logic [35:0] b);
    if (b == ONE) return a;
    if (a == ONE) return b;
    return a ^ b;
  endfunction

  assign bus.iMUL_VALID = injValid || mValid;
  assign bus.iMUL_DATA  = injValid ? injData : mData;
  assign bus.iMUL_BUSY  = forceBusy || mFull;

  always @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET || iRESET_SYNC) begin
      mQueue.delete();
      mRdy.delete();
      mCyc = 0;
      mValid <= 1'b0;
      mFull  <= 1'b0;
      mData  <= '0;
    end else begin
      mCyc = mCyc + 1;
      if (mValid && !bus.oMUL_BUSY) begin
        void'(mQueue.pop_front());
        void'(mRdy.pop_front());
      end
      if (bus.oMUL_REQ && !bus.iMUL_BUSY) begin
        mQueue.push_back(mulModel(bus.oMUL_A, bus.oMUL_B));
        mRdy.push_back(mCyc + 3);
      end
      if (mQueue.size() > 0) begin
        mValid <= (mRdy[0] <= mCyc);
        mData  <= mQueue[0];
      end else begin
        mValid <= 1'b0;
        mData  <= '0;
      end
      mFull <= (mQueue.size() >= 8);
    end
  end

  // Monitor: accepted issues and delivered results, sampled mid-cycle
  int          cyc = 0;
  int          accReq[$];
  int          accCyc[$];
  logic [43:0] resLog[$];
  logic [43:0] exp_q[$];

  always @(posedge iCLOCK) cyc <= cyc + 1;

  always @(negedge iCLOCK) begin
    for (int n = 0; n < P_N; n++) begin
      if (bus.iREQ_REQ[n] && !bus.oREQ_BUSY[n]) begin
        accReq.push_back(n);
        accCyc.push_back(cyc);
      end
      if (bus.oRES_VALID[n] && !bus.iRES_BUSY[n])
        resLog.push_back({8'(n), bus.oRES_DATA});
    end
  end

  // Scoreboard counters and comparison
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResults(input string tag);
    check({tag, "_count"}, 64'(resLog.size()), 64'(exp_q.size()));
    while (resLog.size() > 0 && exp_q.size() > 0)
      check(tag, 64'(resLog.pop_front()), 64'(exp_q.pop_front()));
  endtask

  // Driver tasks
  logic [35:0] opA [P_N][4];
  logic [35:0] opB [P_N][4];
  int          opCnt [P_N];
  int          opIdx [P_N];

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic clearOps();
    for (int n = 0; n < P_N; n++) begin
      opCnt[n] = 0;
      opIdx[n] = 0;
    end
  endtask

  task automatic clearLogs();
    accReq.delete();
    accCyc.delete();
    resLog.delete();
    exp_q.delete();
  endtask

  task automatic applyReq();
    for (int n = 0; n < P_N; n++) begin
      if (opIdx[n] < opCnt[n]) begin
        bus.iREQ_REQ[n] = 1'b1;
        bus.iREQ_A[36*n +: 36] = opA[n][opIdx[n]];
        bus.iREQ_B[36*n +: 36] = opB[n][opIdx[n]];
      end else begin
        bus.iREQ_REQ[n] = 1'b0;
      end
    end
  endtask

  // Each requester holds its current op until it transfers, then moves on.
  task automatic drive(input int cycles);
    repeat (cycles) begin
      applyReq();
      @(negedge iCLOCK);
      for (int n = 0; n < P_N; n++)
        if (bus.iREQ_REQ[n] && !bus.oREQ_BUSY[n]) opIdx[n]++;
      tick();
    end
    bus.iREQ_REQ = '0;
  endtask

  task automatic syncReset();
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
  endtask

  task automatic waitRes(input int n);
    for (int i = 0; i < 40 && resLog.size() < n; i++) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    inRESET = 1'b0;
    iRESET_SYNC = 1'b0;
    forceBusy = 1'b0;
    injValid = 1'b0;
    injData = '0;
    bus.iREQ_REQ = '1;
    bus.iREQ_A = '0;
    bus.iREQ_B = '0;
    bus.iRES_BUSY = '0;
    clearOps();
    repeat (3) tick();
    #1;
    // Reset values, with every requester asking
    check("reset_mul_req", 64'(bus.oMUL_REQ), 64'd0);
    check("reset_mul_a", 64'(bus.oMUL_A), 64'd0);
    check("reset_mul_b", 64'(bus.oMUL_B), 64'd0);
    check("reset_req_busy", 64'(bus.oREQ_BUSY), 64'hf);
    check("reset_res_valid", 64'(bus.oRES_VALID), 64'd0);
    check("reset_orphan", 64'(bus.oERR_ORPHAN), 64'd0);
    bus.iREQ_REQ = '0;
    inRESET = 1'b1;
    tick();
    tick();

    // T1: 1.0 * 1.0 on requester 2
    clearLogs();
    opCnt[2] = 1;
    opA[2][0] = ONE;
    opB[2][0] = ONE;
    applyReq();
    #1;
    check("t1_grant", 64'(bus.oREQ_BUSY), 64'b1011);
    drive(1);
    #1;
    check("t1_mul_req", 64'(bus.oMUL_REQ), 64'd1);
    check("t1_mul_a", 64'(bus.oMUL_A), 64'(ONE));
    check("t1_mul_b", 64'(bus.oMUL_B), 64'(ONE));
    exp_q.push_back({8'd2, ONE});
    waitRes(1);
    repeat (4) tick();
    checkResults("t1_res");

    // T2: all four requesters, two ops each, B=0 so result echoes A
    syncReset();
    clearLogs();
    clearOps();
    for (int n = 0; n < P_N; n++) begin
      opCnt[n] = 2;
      for (int k = 0; k < 2; k++) begin
        opA[n][k] = 36'hA00000000 + 36'(n*16 + k);
        opB[n][k] = '0;
      end
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back({8'(i%4), 36'hA00000000 + 36'((i%4)*16 + i/4)});
    drive(12);
    waitRes(8);
    check("t2_acc_count", 64'(accReq.size()), 64'd8);
    for (int i = 0; i < 8 && i < accReq.size(); i++)
      check("t2_grant", 64'(accReq[i]), 64'(i%4));
    if (accCyc.size() == 8)
      check("t2_back_to_back", 64'(accCyc[7] - accCyc[0]), 64'd7);
    checkResults("t2_res");

    // T3a: multiplier input busy freezes the staging register
    clearLogs();
    clearOps();
    forceBusy = 1'b1;
    opCnt[2] = 1;
    opA[2][0] = 36'h111111111;
    opB[2][0] = '0;
    drive(1);
    opCnt[3] = 1;
    opA[3][0] = 36'h333333333;
    opB[3][0] = 36'h0000000ff;
    drive(4);
    #1;
    check("t3a_acc_count", 64'(accReq.size()), 64'd1);
    check("t3a_mul_req", 64'(bus.oMUL_REQ), 64'd1);
    check("t3a_mul_a", 64'(bus.oMUL_A), 64'h111111111);
    check("t3a_mul_b", 64'(bus.oMUL_B), 64'd0);
    applyReq();
    #1;
    check("t3a_req_busy", 64'(bus.oREQ_BUSY), 64'hf);
    forceBusy = 1'b0;
    drive(3);
    exp_q.push_back({8'd2, 36'h111111111});
    exp_q.push_back({8'd3, 36'h3333333cc});
    waitRes(2);
    checkResults("t3a_res");

    // T3b: results stalled, tag FIFO fills to 8, one pop lets one more in
    syncReset();
    clearLogs();
    clearOps();
    bus.iRES_BUSY = 4'hf;
    for (int n = 0; n < P_N; n++) begin
      opCnt[n] = 3;
      for (int k = 0; k < 3; k++) begin
        opA[n][k] = 36'hB00000000 + 36'(n*16 + k);
        opB[n][k] = '0;
      end
    end
    drive(20);
    check("t3b_acc_count", 64'(accReq.size()), 64'd8);
    for (int i = 0; i < 8 && i < accReq.size(); i++)
      check("t3b_grant", 64'(accReq[i]), 64'(i%4));
    applyReq();
    #1;
    check("t3b_req_busy_full", 64'(bus.oREQ_BUSY), 64'hf);
    check("t3b_mul_busy", 64'(bus.oMUL_BUSY), 64'd1);
    check("t3b_res_valid", 64'(bus.oRES_VALID), 64'b0001);
    check("t3b_no_delivery", 64'(resLog.size()), 64'd0);
    bus.iRES_BUSY = 4'b1110;
    drive(1);
    bus.iRES_BUSY = 4'hf;
    drive(8);
    check("t3b_refill_count", 64'(accReq.size()), 64'd9);
    if (accReq.size() >= 9)
      check("t3b_refill_req", 64'(accReq[8]), 64'd0);
    check("t3b_one_pop", 64'(resLog.size()), 64'd1);
    bus.iRES_BUSY = '0;
    for (int i = 0; i < 9; i++)
      exp_q.push_back({8'(i%4), 36'hB00000000 + 36'((i%4)*16 + i/4)});
    waitRes(9);
    checkResults("t3b_res");

    // T4: requester 1 stalls its result for five cycles
    clearLogs();
    clearOps();
    bus.iRES_BUSY = 4'b0010;
    opCnt[1] = 1;
    opA[1][0] = 36'h123456789;
    opB[1][0] = 36'h0f0f0f0f0;
    drive(2);
    for (int i = 0; i < 20 && bus.oRES_VALID != 4'b0010; i++) tick();
    #1;
    check("t4_valid", 64'(bus.oRES_VALID), 64'b0010);
    repeat (5) begin
      check("t4_mul_busy", 64'(bus.oMUL_BUSY), 64'd1);
      check("t4_hold_valid", 64'(bus.oRES_VALID), 64'b0010);
      tick();
    end
    check("t4_no_pop", 64'(resLog.size()), 64'd0);
    bus.iRES_BUSY = '0;
    repeat (5) tick();
    #1;
    check("t4_after_valid", 64'(bus.oRES_VALID), 64'd0);
    exp_q.push_back({8'd1, 36'h1d3b59779});
    checkResults("t4_res");

    // T5: result with no tag outstanding
    clearLogs();
    injData = 36'hdeadbeef0;
    injValid = 1'b1;
    #1;
    check("t5_res_valid", 64'(bus.oRES_VALID), 64'd0);
    check("t5_mul_busy", 64'(bus.oMUL_BUSY), 64'd0);
    check("t5_orphan_before", 64'(bus.oERR_ORPHAN), 64'd0);
    tick();
    injValid = 1'b0;
    #1;
    check("t5_orphan_set", 64'(bus.oERR_ORPHAN), 64'd1);
    repeat (3) tick();
    check("t5_orphan_held", 64'(bus.oERR_ORPHAN), 64'd1);
    check("t5_no_result", 64'(resLog.size()), 64'd0);
    syncReset();
    #1;
    check("t5_orphan_clear", 64'(bus.oERR_ORPHAN), 64'd0);

    // T6: async reset with three ops in flight
    clearLogs();
    clearOps();
    for (int n = 0; n < 3; n++) begin
      opCnt[n] = 1;
      opA[n][0] = 36'hC00000000 + 36'(n);
      opB[n][0] = '0;
    end
    drive(3);
    check("t6_acc_count", 64'(accReq.size()), 64'd3);
    bus.iREQ_REQ = '1;
    #2;
    inRESET = 1'b0;
    #1;
    check("t6_mul_req", 64'(bus.oMUL_REQ), 64'd0);
    check("t6_mul_a", 64'(bus.oMUL_A), 64'd0);
    check("t6_mul_b", 64'(bus.oMUL_B), 64'd0);
    check("t6_req_busy", 64'(bus.oREQ_BUSY), 64'hf);
    check("t6_res_valid", 64'(bus.oRES_VALID), 64'd0);
    check("t6_mul_busy", 64'(bus.oMUL_BUSY), 64'd0);
    tick();
    tick();
    bus.iREQ_REQ = '0;
    inRESET = 1'b1;
    repeat (10) tick();
    check("t6_dropped", 64'(resLog.size()), 64'd0);
    clearOps();
    opCnt[3] = 1;
    opA[3][0] = 36'h000000005;
    opB[3][0] = ONE;
    exp_q.push_back({8'd3, 36'h000000005});
    drive(2);
    waitRes(1);
    repeat (3) tick();
    checkResults("t6_res");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
